pwm_capture_array: RTL and testbench
====================================

# pwm_capture_array

Parametrised multi-channel successor to the single-channel inverse-PWM measurer used by the MazeRunner physics model. Measures the high time of NCH motor PWM signals over a common fixed window of 2^CNT_W clocks. Publishes unsigned and direction-signed duty per channel, plus saturation flags, with one shared valid strobe. Sits between the DUT motor-drive outputs and the physics/alpha computation in the bench, and is synthesisable for on-chip self-test.

## Interface
Parameters:
- NCH, 2, number of PWM/DIR channel pairs (1..8)
- CNT_W, 11, window counter and duty width; window length 2^CNT_W clocks

Ports:
- clk  in  1  system clock
- RST_n  in  1  reset, asynchronous, active-low
- pwm  in  NCH  raw PWM inputs, bit i = channel i
- dir  in  NCH  direction per channel; 1 => reverse (negative), 0 => forward
- clr  in  1  synchronous window restart; discards partial counts
- duty  out  NCH*CNT_W  unsigned duty of the last completed window, channel i at [i*CNT_W +: CNT_W]
- duty_s  out  NCH*(CNT_W+1)  signed duty, two's complement, channel i at [i*(CNT_W+1) +: CNT_W+1]
- sat  out  NCH  channel high for every counted cycle of the last window
- zero  out  NCH  channel never high during the last window
- vld  out  1  one-cycle pulse; all outputs updated on the same edge
- wcnt  out  8  completed-window counter, wraps 255 -> 0

## Operation
- Shared window counter per_cnt (CNT_W bits) increments every clock and wraps to 0.
- Terminal cycle: per_cnt all ones.
- Per-channel hcnt[i] (CNT_W bits):
  - cleared on the terminal cycle;
  - otherwise incremented when the conditioned pwm[i] is 1.
- Because the terminal-cycle sample is never counted, the maximum duty is 2^CNT_W-1. hcnt cannot overflow.
- On the terminal cycle, the next edge does all of the following together:
  - duty[i] <= hcnt[i]
  - duty_s[i] <= dir[i] ? -{0,hcnt[i]} : {0,hcnt[i]}, using dir as seen on the terminal cycle
  - sat[i] <= (hcnt[i] == 2^CNT_W-1)
  - zero[i] <= (hcnt[i] == 0)
  - vld <= 1
  - wcnt <= wcnt+1
- Negated zero duty is 0. duty_s never overflows, because CNT_W+1 bits hold -(2^CNT_W-1).
- clr = 1: per_cnt and all hcnt go to 0 on the next edge; vld stays 0; duty/duty_s/sat/zero/wcnt hold.
- clr asserted on the terminal cycle: clr wins. No latch, no vld, and the outputs hold.
- Holding clr high stalls the window. The first terminal cycle occurs 2^CNT_W-1 clocks after the first edge with clr = 0.

## Timing
- Reset values: duty = 0, duty_s = 0, sat = 0, zero = 0, vld = 0, wcnt = 0.
- Internally, per_cnt = 0, hcnt = 0, and filter state = 0.
- RST_n assertion mid-window discards all partial counts immediately (asynchronous).
- vld period is exactly 2^CNT_W clocks when clr is idle.
- vld is high for exactly one cycle.
- Latency from a pwm/dir change to its effect on the count:
  - 0 clocks without the filter (macro off);
  - 4 clocks with the filter (2 sync + 2 majority pipeline).
- There is no back-pressure. A consumer that misses vld sees outputs overwritten at the next window; wcnt lets it detect skipped windows.

## Configuration
- PWM_CAP_GLITCH_FILT_EN defined:
  - pwm and dir each pass through a 2-flop synchroniser, then a 3-sample majority filter (shift register of the last 3 synchronised samples).
  - Isolated 1-cycle pulses or drops are rejected.
  - Counting and dir sampling use the filtered signals.
- Not defined:
  - pwm and dir are used directly; the inputs are assumed synchronous to clk.
  - A 1-cycle pulse counts 1.

## Structure
- Package pwm_cap_pkg holds:
  - the localparam helper DUTY_MAX(CNT_W) = 2^CNT_W-1;
  - the function sign_duty(mag, dir).
- One sub-module, pwm_cap_filt: a single-bit synchroniser plus majority filter, instantiated 2*NCH times under the macro.
- Top level holds:
  - the shared per_cnt;
  - a generate loop of NCH hcnt/output slices;
  - vld/wcnt logic.

## Test plan
All scenarios use NCH=2 and CNT_W=11, and align pwm to the window (per_cnt=0).
- pwm[0] high for cycles 0..1023, low otherwise; dir[0]=0 -> at vld: duty[0]=1024, duty_s[0]=+1024, sat=0, zero=0.
- pwm[1] constant 1 with dir[1]=1; pwm[0] constant 0 -> duty[1]=2047, duty_s[1]=-2047, sat[1]=1; duty[0]=0, zero[0]=1.
- Three windows of 512-cycle high on channel 0 -> vld pulses exactly 2048 clocks apart; wcnt=1,2,3; all three windows give duty[0]=512.
- clr pulsed at per_cnt=1000, and separately on the terminal cycle -> no vld until 2047 clocks after clr deasserts; outputs hold their prior values.
- RST_n dropped mid-window -> all outputs 0 immediately; first vld after release reports only post-reset counts.
- 100 isolated 1-cycle pwm pulses per window -> duty=100 with the macro off; duty=0 with PWM_CAP_GLITCH_FILT_EN on.

Source files
------------

// File: rtl/pwm_cap_pkg.sv
// Shared constants and helpers for the multi-channel PWM duty capture block.
// The optional input conditioning is enabled by PWM_CAP_GLITCH_FILT_EN.
package pwm_cap_pkg;

    localparam int unsigned MAG_W = 32;

    // Largest count a window can report: the terminal-cycle sample is never counted.
    function automatic logic [MAG_W-1:0] duty_max(input int unsigned w);
        return MAG_W'((64'd1 << w) - 64'd1);
    endfunction

    // Direction-signed duty; a zero magnitude stays zero when negated.
    function automatic logic [MAG_W:0] sign_duty(input logic [MAG_W-1:0] mag, input logic rev);
        logic [MAG_W:0] ext;
        ext = {1'b0, mag};
        return rev ? (~ext + (MAG_W+1)'(1)) : ext;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/pwm_cap_filt.sv
// Single-bit 2-flop synchroniser followed by a 3-sample majority vote.
// Used only when PWM_CAP_GLITCH_FILT_EN is defined; latency is 4 clocks.
module pwm_cap_filt
    import pwm_cap_pkg::*;
(
    input  logic clk,
    input  logic RST_n,
    input  logic d,
    output logic q
);

    logic       s1;
    logic       s2;
    logic [1:0] hist;

    // s2 plus hist form the last three synchronised samples
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            hist <= 2'b00;
            q    <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            hist <= {hist[0], s2};
            q    <= maj3(s2, hist[0], hist[1]);
        end
    end

endmodule

// File: rtl/pwm_capture_array.sv
// NCH-channel PWM high-time measurer over a shared 2^CNT_W clock window.
// Define PWM_CAP_GLITCH_FILT_EN to synchronise and majority-filter pwm/dir.
module pwm_capture_array
    import pwm_cap_pkg::*;
#(
    parameter int unsigned NCH   = 2,
    parameter int unsigned CNT_W = 11
)
(
    input  logic                     clk,
    input  logic                     RST_n,
    input  logic [NCH-1:0]           pwm,
    input  logic [NCH-1:0]           dir,
    input  logic                     clr,
    output logic [NCH*CNT_W-1:0]     duty,
    output logic [NCH*(CNT_W+1)-1:0] duty_s,
    output logic [NCH-1:0]           sat,
    output logic [NCH-1:0]           zero,
    output logic                     vld,
    output logic [7:0]               wcnt
);

    localparam int unsigned SW = CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(duty_max(CNT_W));

    logic [NCH-1:0]   pwm_cond;
    logic [NCH-1:0]   dir_cond;
    logic [CNT_W-1:0] per_cnt;
    logic             terminal_c;
    logic             latch_c;

`ifdef PWM_CAP_GLITCH_FILT_EN
    for (genvar i = 0; i < int'(NCH); i++) begin : g_filt
        pwm_cap_filt u_pwm_filt (.clk(clk), .RST_n(RST_n), .d(pwm[i]), .q(pwm_cond[i]));
        pwm_cap_filt u_dir_filt (.clk(clk), .RST_n(RST_n), .d(dir[i]), .q(dir_cond[i]));
    end
`else
    assign pwm_cond = pwm;
    assign dir_cond = dir;
`endif

    assign terminal_c = (per_cnt == CNT_MAX);
    // clr on the terminal cycle suppresses the window result
    assign latch_c    = terminal_c & ~clr;

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            per_cnt <= '0;
        end else if (clr) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            vld  <= 1'b0;
            wcnt <= 8'd0;
        end else begin
            vld <= latch_c;
            if (latch_c) begin
                wcnt <= wcnt + 8'd1;
            end
        end
    end

    for (genvar i = 0; i < int'(NCH); i++) begin : g_ch
        logic [CNT_W-1:0] hcnt;
        logic [CNT_W-1:0] duty_r;
        logic [SW-1:0]    duty_s_r;
        logic             sat_r;
        logic             zero_r;

        // High-time accumulator; the terminal-cycle sample is never counted
        always_ff @(posedge clk or negedge RST_n) begin
            if (!RST_n) begin
                hcnt <= '0;
            end else if (clr || terminal_c) begin
                hcnt <= '0;
            end else if (pwm_cond[i]) begin
                hcnt <= hcnt + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge RST_n) begin
            if (!RST_n) begin
                duty_r   <= '0;
                duty_s_r <= '0;
                sat_r    <= 1'b0;
                zero_r   <= 1'b0;
            end else if (latch_c) begin
                duty_r   <= hcnt;
                duty_s_r <= SW'(sign_duty(MAG_W'(hcnt), dir_cond[i]));
                sat_r    <= (hcnt == CNT_MAX);
                zero_r   <= (hcnt == '0);
            end
        end

        assign duty[i*CNT_W +: CNT_W] = duty_r;
        assign duty_s[i*SW +: SW]     = duty_s_r;
        assign sat[i]                 = sat_r;
        assign zero[i]                = zero_r;
    end

endmodule

// File: tb/tb_pwm_capture_array.sv
// Directed scoreboard bench for pwm_capture_array with NCH=2, CNT_W=11.
module tb_pwm_capture_array;

    localparam int unsigned NCH   = 2;
    localparam int unsigned CNT_W = 11;
    localparam int unsigned WIN   = 2048;

    typedef struct {
        logic [21:0] duty;
        logic [23:0] duty_s;
        logic [1:0]  sat;
        logic [1:0]  zero;
        logic [7:0]  wcnt;
    } exp_t;

    logic        clk;
    logic        RST_n;
    logic [1:0]  pwm;
    logic [1:0]  dir;
    logic        clr;
    logic [21:0] duty;
    logic [23:0] duty_s;
    logic [1:0]  sat;
    logic [1:0]  zero;
    logic        vld;
    logic [7:0]  wcnt;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic prev_vld = 1'b0;
    exp_t sb[$];
    int   vld_cyc[$];

    pwm_capture_array #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk(clk), .RST_n(RST_n), .pwm(pwm), .dir(dir), .clr(clr),
        .duty(duty), .duty_s(duty_s), .sat(sat), .zero(zero),
        .vld(vld), .wcnt(wcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input int d0, input int d1, input bit r0, input bit r1,
                                    input int w);
        exp_t e;
        logic [11:0] s0, s1;
        s0 = r0 ? 12'(4096 - d0) : 12'(d0);
        s1 = r1 ? 12'(4096 - d1) : 12'(d1);
        e.duty   = {11'(d1), 11'(d0)};
        e.duty_s = {s1, s0};
        e.sat    = {d1 == 2047, d0 == 2047};
        e.zero   = {d1 == 0, d0 == 0};
        e.wcnt   = 8'(w);
        return e;
    endfunction

    // Pops one expected record per vld pulse
    always @(negedge clk) begin
        exp_t e;
        if (vld === 1'b1) begin
            vld_cyc.push_back(cyc);
            chk("vld_one_cycle", 32'(prev_vld), 32'd0);
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_vld observed=vld expected=no_vld cyc=%0d", cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("duty", 32'(duty), 32'(e.duty));
                chk("duty_s", 32'(duty_s), 32'(e.duty_s));
                chk("sat", 32'(sat), 32'(e.sat));
                chk("zero", 32'(zero), 32'(e.zero));
                chk("wcnt", 32'(wcnt), 32'(e.wcnt));
            end
        end
        prev_vld = vld;
    end

    // Drive n cycles from window offset 0; pwm[i] high while c < hi_i
    task automatic run_cycles(input int n, input int hi0, input int hi1, input bit r0,
                              input bit r1, input bit gl0, input bit clr_last);
        for (int c = 0; c < n; c++) begin
            pwm[0] = gl0 ? ((c % 10 == 5) && (c < 1000)) : (c < hi0);
            pwm[1] = (c < hi1);
            dir    = {r1, r0};
            clr    = clr_last && (c == n - 1);
            @(negedge clk);
        end
        clr = 1'b0;
        pwm = 2'b00;
    endtask

    initial begin
        int clr_cyc;
        int gl_exp;
        RST_n = 1'b0;
        pwm   = 2'b00;
        dir   = 2'b00;
        clr   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_duty", 32'(duty), 32'd0);
        chk("rst_duty_s", 32'(duty_s), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_wcnt", 32'(wcnt), 32'd0);
        RST_n = 1'b1;

        // half-duty forward window
        sb.push_back(mk_exp(1024, 0, 1'b0, 1'b0, 1));
        run_cycles(WIN, 1024, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // channel 1 saturated reverse, channel 0 idle
        sb.push_back(mk_exp(0, 2047, 1'b0, 1'b1, 2));
        run_cycles(WIN, 0, WIN, 1'b0, 1'b1, 1'b0, 1'b0);

        // three back-to-back quarter-duty reverse windows
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk_exp(512, 0, 1'b1, 1'b0, 3 + k));
            run_cycles(WIN, 512, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        #1;
        chk("vld_period_a", 32'(vld_cyc[$] - vld_cyc[$-1]), 32'(WIN));
        chk("vld_period_b", 32'(vld_cyc[$-1] - vld_cyc[$-2]), 32'(WIN));

        // clr mid-window at offset 1000
        run_cycles(1001, WIN, WIN, 1'b0, 1'b0, 1'b0, 1'b1);
        clr_cyc = cyc;
        #1;
        chk("clr_hold_duty", 32'(duty), 32'({11'd0, 11'd512}));
        chk("clr_hold_wcnt", 32'(wcnt), 32'd5);
        chk("clr_no_vld", 32'(vld), 32'd0);
        sb.push_back(mk_exp(300, 700, 1'b0, 1'b0, 6));
        run_cycles(WIN, 300, 700, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("clr_restart_gap", 32'(vld_cyc[$] - clr_cyc), 32'(WIN));

        // clr on the terminal cycle wins
        run_cycles(WIN, WIN, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("clr_term_wcnt", 32'(wcnt), 32'd6);
        chk("clr_term_vld", 32'(vld), 32'd0);
        chk("clr_term_duty", 32'(duty), 32'({11'd700, 11'd300}));

        // asynchronous reset mid-window
        run_cycles(700, WIN, WIN, 1'b1, 1'b1, 1'b0, 1'b0);
        RST_n = 1'b0;
        #1;
        chk("mrst_duty", 32'(duty), 32'd0);
        chk("mrst_duty_s", 32'(duty_s), 32'd0);
        chk("mrst_sat", 32'(sat), 32'd0);
        chk("mrst_zero", 32'(zero), 32'd0);
        chk("mrst_wcnt", 32'(wcnt), 32'd0);
        @(negedge clk);
        RST_n = 1'b1;
        sb.push_back(mk_exp(100, 2047, 1'b0, 1'b0, 1));
        run_cycles(WIN, 100, WIN, 1'b0, 1'b0, 1'b0, 1'b0);

        // 100 isolated single-cycle pulses on channel 0
`ifdef PWM_CAP_GLITCH_FILT_EN
        gl_exp = 0;
`else
        gl_exp = 100;
`endif
        sb.push_back(mk_exp(gl_exp, 0, 1'b0, 1'b0, 2));
        run_cycles(WIN, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
